// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer in front of single-ported DATA_MEMORY.
// Port 0 = core load/store, port 1 = loader/debug. One request is latched, driven
// as a single access cycle, and load data is returned registered with an rvalid pulse.
// Optional feature: define DMEM_ARB_FIXED_PRIORITY_EN for fixed priority (port 0
// always wins a conflict); otherwise conflicts are resolved round-robin.
module dmem_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [2:0]        mtype0,
    input  logic [2:0]        mtype1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic [2:0]        mem_mem_type,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // WAIT counts down from RD_LATENCY-1 to 0; unused when RD_LATENCY is 0.
    localparam logic [1:0] WAIT_INIT = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

    logic [1:0]        state;
    logic [1:0]        wait_cnt;
    logic              lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [2:0]        lat_mtype;
    logic              winner;
    logic              any_req;

    assign any_req = req0 | req1;

`ifndef DMEM_ARB_FIXED_PRIORITY_EN
    logic last_grant;

    // Round-robin history: remembers the port granted on each IDLE->ACCESS move
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (state == ST_IDLE && any_req) begin
            last_grant <= winner;
        end
    end
`endif

    // Winner selection among the currently asserted requests
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
            winner = 1'b0;
`else
            winner = ~last_grant;
`endif
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    // Sequencer FSM and request latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_mtype <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state     <= ST_ACCESS;
                        lat_id    <= winner;
                        lat_we    <= winner ? we1 : we0;
                        lat_addr  <= winner ? addr1 : addr0;
                        lat_wdata <= winner ? wdata1 : wdata0;
                        lat_mtype <= winner ? mtype1 : mtype0;
                    end
                end
                ST_ACCESS: begin
                    if (lat_we) begin
                        state <= ST_IDLE;
                    end else if (RD_LATENCY > 0) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end else begin
                        state <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Load data capture: end of ACCESS for zero latency, else end of last WAIT cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if ((state == ST_ACCESS && !lat_we && RD_LATENCY == 0) ||
                     (state == ST_WAIT && wait_cnt == '0)) begin
            rdata <= mem_read_data;
        end
    end

    // Output decode from state and latched request only (no req-to-mem path)
    always_comb begin
        gnt0             = (state == ST_ACCESS) && !lat_id;
        gnt1             = (state == ST_ACCESS) &&  lat_id;
        rvalid0          = (state == ST_RESP)   && !lat_id;
        rvalid1          = (state == ST_RESP)   &&  lat_id;
        busy             = (state != ST_IDLE);
        mem_write_enable = (state == ST_ACCESS) &&  lat_we;
        mem_read_enable  = (state == ST_ACCESS) && !lat_we;
        mem_write_data   = mem_write_enable ? lat_wdata : '0;
        mem_address      = lat_addr;
        mem_mem_type     = lat_mtype;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the single-ported DATA_MEMORY.
- Requester 0: core load/store path. Requester 1: loader/debug port.
- Latches one request, drives a single clean access cycle into DATA_MEMORY, waits the memory read latency, and returns registered read data with a one-cycle valid pulse.
- Round-robin by default; fixed priority is optional.

Parameters:
- ADDR_W, 4, address width; matches DATA_MEMORY address port.
- DATA_W, 32, data width.
- RD_LATENCY, 1, cycles from the end of the access cycle to valid mem_read_data; legal range 0..3.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request; held stable until the matching gnt.
- we0 / we1  in  1  1 = store, 0 = load.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  store data.
- mtype0 / mtype1  in  3  byte/half/word, signed/unsigned; DATA_MEMORY encoding, passed unchanged.
- gnt0 / gnt1  out  1  one-cycle pulse, request accepted; requester may drop or change req afterwards.
- rvalid0 / rvalid1  out  1  one-cycle pulse, load data valid.
- rdata  out  DATA_W  registered load data, shared; qualified by rvalid0/1.
- busy  out  1  high in any state other than IDLE.
- mem_address  out  ADDR_W  to DATA_MEMORY address.
- mem_write_data  out  DATA_W  to DATA_MEMORY write_data.
- mem_write_enable  out  1  to DATA_MEMORY write_enable.
- mem_read_enable  out  1  to DATA_MEMORY read_enable.
- mem_mem_type  out  3  to DATA_MEMORY mem_type.
- mem_read_data  in  DATA_W  from DATA_MEMORY read_data.

Behaviour:
- Reset (reset low, async): state = IDLE; gnt0/1, rvalid0/1, busy, all mem_* outputs = 0; rdata = 0; last_grant = 1, so port 0 wins first.
- FSM states: IDLE, ACCESS, WAIT, RESP. All outputs are registered or decoded from state plus registers. No combinational path from req to mem_*.
- IDLE:
  - Any req → select winner, latch we/addr/wdata/mtype/id, go to ACCESS.
  - No req → stay in IDLE.
- Winner selection:
  - Single req → that port.
  - Both req → the port != last_grant.
  - last_grant updates on every IDLE→ACCESS transition.
- ACCESS (exactly 1 cycle):
  - gnt[id] = 1.
  - mem_address/mem_mem_type come from the latch.
  - Store: mem_write_enable = 1, mem_write_data = latched wdata; next state IDLE.
  - Load: mem_read_enable = 1, mem_write_data = 0; next state WAIT if RD_LATENCY > 0, else RESP with mem_read_data captured at the end of ACCESS.
- WAIT:
  - mem enables = 0; mem_address/mem_mem_type held.
  - Counts RD_LATENCY cycles.
  - Captures mem_read_data into rdata at the end of the last WAIT cycle, then goes to RESP.
- RESP (1 cycle): rvalid[id] = 1, rdata stable; next state IDLE.
- Timing:
  - Load: req seen in cycle 0, gnt in cycle 1, rvalid in cycle 2+RD_LATENCY.
  - Store: gnt in cycle 1, memory written at the end of cycle 1, next accept possible in cycle 2.
- rdata holds its last captured value until the next load capture; it is not cleared after RESP.
- A req that arrives or drops during a non-IDLE state is only sampled on return to IDLE; there is no queueing.
- Reset mid-operation: the pending access is dropped, no gnt/rvalid is emitted, and a store that has not yet reached ACCESS is never written.
- gnt0 and gnt1 are never high together; likewise rvalid0 and rvalid1.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIORITY_EN.
- Defined: port 0 always wins when both req; last_grant is unused.
- Undefined: round-robin as above.

Test Plan:
- Single store then load, port 0, RD_LATENCY=1: store addr=0, wdata=6, mtype=000 → gnt0 in cycle 1 with mem_write_enable=1. Then load addr=0 → gnt0, and rvalid0 three cycles after req with rdata=6.
- Both req held continuously, all loads → grants alternate 0,1,0,1; gnt0/gnt1 never overlap; each rvalid goes to the matching port.
- Back-to-back stores on port 1 to addr 3,4,5 with data 0xA,0xB,0xC → a gnt1 pulse every 2 cycles; later loads return 0xA/0xB/0xC.
- Reset asserted in WAIT during a port-1 load → outputs 0 immediately; no rvalid1 after release; first post-reset conflict is granted to port 0.
- RD_LATENCY=0 and RD_LATENCY=3 builds, load of stored 0x12345678 → rvalid at cycle 2 and cycle 5 respectively, rdata=0x12345678.
- With DMEM_ARB_FIXED_PRIORITY_EN, both req held for 4 accesses → gnt0 on every access, gnt1 never.
